// File: rtl/ddr5_pkg.sv
// Shared types, address-map bit positions and the address decoder for the
// DDR5 request queue.
package ddr5_pkg;

  localparam int REQ_CYC_W = 64;
  localparam int ADDR_W    = 34;
  localparam int CORE_W    = 4;
  localparam int ROW_W     = 16;
  localparam int COL_W     = 10;

  localparam int BYTE_SEL_LSB = 0;
  localparam int BYTE_SEL_W   = 2;
  localparam int LOW_COL_LSB  = 2;
  localparam int LOW_COL_W    = 4;
  localparam int CHANNEL_BIT  = 6;
  localparam int BG_LSB       = 7;
  localparam int BG_W         = 3;
  localparam int BANK_LSB     = 10;
  localparam int BANK_W       = 2;
  localparam int HIGH_COL_LSB = 12;
  localparam int HIGH_COL_W   = 6;
  localparam int ROW_LSB      = 18;

  typedef enum logic [1:0] {
    READ   = 2'd0,
    WRITE  = 2'd1,
    IFETCH = 2'd2
  } opn_t;

  typedef struct packed {
    logic [REQ_CYC_W-1:0] cyc;
    logic [CORE_W-1:0]    core;
    opn_t                 opn;
    logic [BYTE_SEL_W-1:0] byte_sel;
    logic                 channel;
    logic [BG_W-1:0]      bank_group;
    logic [BANK_W-1:0]    bank;
    logic [ROW_W-1:0]     row;
    logic [COL_W-1:0]     column;
    logic [ADDR_W-1:0]    addr;
  } req_t;

  // Fills only the address-derived fields; cyc, core and opn are left zero.
  function automatic req_t decode_addr(input logic [ADDR_W-1:0] addr);
    req_t r;
    r            = '0;
    r.byte_sel   = addr[BYTE_SEL_LSB +: BYTE_SEL_W];
    r.channel    = addr[CHANNEL_BIT];
    r.bank_group = addr[BG_LSB +: BG_W];
    r.bank       = addr[BANK_LSB +: BANK_W];
    r.row        = addr[ROW_LSB +: ROW_W];
    r.column     = {addr[HIGH_COL_LSB +: HIGH_COL_W], addr[LOW_COL_LSB +: LOW_COL_W]};
    r.addr       = addr;
    return r;
  endfunction

endpackage

// File: rtl/ddr5_sync_fifo.sv
// Single-clock in-order FIFO with synchronous active-high reset; full/empty
// are derived from the occupancy count.
module ddr5_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count decides which entries
  // are meaningful, and leaving the array reset-free keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ddr5_req_queue.sv
// DDR5 request queue: holds timestamped CPU requests until due, drops illegal
// ones, decodes legal ones into DRAM fields and buffers them in order.
// Optional statistics (full_cycles, max_count) under DDR5_REQQ_STATS_EN.
module ddr5_req_queue
  import ddr5_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int NUM_CORES = 13,
  parameter int CYC_W     = REQ_CYC_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CYC_W-1:0]       in_cyc,
  input  logic [3:0]             in_core,
  input  logic [1:0]             in_opn,
  input  logic [33:0]            in_addr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output req_t                   out_req,
  output logic [CYC_W-1:0]       cur_cyc,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic [15:0]            drop_cnt
`ifdef DDR5_REQQ_STATS_EN
  ,
  output logic [31:0]            full_cycles,
  output logic [$clog2(DEPTH):0] max_count
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CYC_W-1:0] cur_cyc_q, cur_cyc_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic             due, illegal, accept, push, pop;
  logic             fifo_empty;
  req_t             wr_entry, fifo_rdata;

  always_comb begin
    cur_cyc_d = cur_cyc_q + CYC_W'(1);
    due       = (cur_cyc_q >= in_cyc);
    illegal   = ({1'b0, in_core} >= 5'(NUM_CORES)) || (in_opn == 2'd3) || in_addr[CHANNEL_BIT];
    // Illegal requests are always consumed once due, even into a full queue.
    in_ready  = !rst && due && (illegal || !full);
    accept    = in_valid && in_ready;
    push      = accept && !illegal;
    pop       = out_valid && out_ready;

    drop_cnt_d = drop_cnt_q;
    if (accept && illegal && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;

    wr_entry      = decode_addr(in_addr);
    wr_entry.cyc  = in_cyc;
    wr_entry.core = in_core;
    wr_entry.opn  = opn_t'(in_opn);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_cyc_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      cur_cyc_q  <= cur_cyc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  ddr5_sync_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (fifo_rdata),
    .count (count),
    .full  (full),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  // Head is forced to zero while empty so the reset-free storage never leaks out.
  assign out_req   = fifo_empty ? '0 : fifo_rdata;
  assign cur_cyc   = cur_cyc_q;
  assign drop_cnt  = drop_cnt_q;

`ifdef DDR5_REQQ_STATS_EN
  logic [31:0]      full_cycles_q, full_cycles_d;
  logic [CNT_W-1:0] max_count_q, max_count_d;

  always_comb begin
    full_cycles_d = full_cycles_q;
    if (full && (full_cycles_q != 32'hFFFF_FFFF)) full_cycles_d = full_cycles_q + 32'd1;
    max_count_d = (count > max_count_q) ? count : max_count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_cycles_q <= '0;
      max_count_q   <= '0;
    end else begin
      full_cycles_q <= full_cycles_d;
      max_count_q   <= max_count_d;
    end
  end

  assign full_cycles = full_cycles_q;
  assign max_count   = max_count_q;

  // Simulation-only trace of cycles spent at capacity.
  always @(posedge clk) begin
    if (!rst && full) $display("ddr5_req_queue: queue at capacity, cur_cyc=%0d", cur_cyc_q);
  end
`endif

endmodule

// File: tb/tb_ddr5_req_queue.sv
// Self-checking bench for ddr5_req_queue against a queue-based reference model.
module tb_ddr5_req_queue;
  import ddr5_pkg::*;

  localparam int DEPTH     = 16;
  localparam int NUM_CORES = 13;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, full;
  logic [63:0] in_cyc, cur_cyc;
  logic [3:0]  in_core;
  logic [1:0]  in_opn;
  logic [33:0] in_addr;
  req_t        out_req;
  logic [4:0]  count;
  logic [15:0] drop_cnt;
`ifdef DDR5_REQQ_STATS_EN
  logic [31:0] full_cycles;
  logic [4:0]  max_count;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [63:0] m_cyc;
  req_t        m_q[$];
  int          m_drop;

  always #5 clk = ~clk;

  ddr5_req_queue dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cyc    (in_cyc),
    .in_core   (in_core),
    .in_opn    (in_opn),
    .in_addr   (in_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_req   (out_req),
    .cur_cyc   (cur_cyc),
    .count     (count),
    .full      (full),
    .drop_cnt  (drop_cnt)
`ifdef DDR5_REQQ_STATS_EN
    ,
    .full_cycles (full_cycles),
    .max_count   (max_count)
`endif
  );

  function automatic req_t model_entry(input logic [63:0] cyc, input logic [3:0] core,
                                       input logic [1:0] opn, input logic [33:0] addr);
    req_t r;
    longint unsigned a;
    a            = longint'(addr);
    r.cyc        = cyc;
    r.core       = core;
    r.opn        = opn_t'(opn);
    r.byte_sel   = 2'(a % 4);
    r.channel    = 1'((a / 64) % 2);
    r.bank_group = 3'((a / 128) % 8);
    r.bank       = 2'((a / 1024) % 4);
    r.row        = 16'(a / 262144);
    r.column     = 10'(((a / 4096) % 64) * 16 + (a / 4) % 16);
    r.addr       = addr;
    return r;
  endfunction

  function automatic bit m_illegal();
    return (int'(in_core) >= NUM_CORES) || (in_opn == 2'd3) || (((in_addr >> 6) & 34'd1) != 0);
  endfunction

  function automatic bit m_ready();
    return !rst && (m_cyc >= in_cyc) && (m_illegal() || m_q.size() < DEPTH);
  endfunction

  // Advance one clock; the model applies the same edge's accept/pop decisions.
  task automatic tick();
    bit rdy, ill, pop;
    rdy = m_ready();
    ill = m_illegal();
    pop = (m_q.size() != 0) && out_ready;
    @(posedge clk);
    if (rst) begin
      m_cyc  = '0;
      m_drop = 0;
      m_q.delete();
    end else begin
      m_cyc = m_cyc + 64'd1;
      if (pop) void'(m_q.pop_front());
      if (in_valid && rdy) begin
        if (ill) begin
          if (m_drop < 65535) m_drop++;
        end else begin
          m_q.push_back(model_entry(in_cyc, in_core, in_opn, in_addr));
        end
      end
    end
    #1;
  endtask

  task automatic drive_legal(input logic [63:0] cyc);
    in_valid = 1'b1;
    in_cyc   = cyc;
    in_core  = 4'($urandom_range(0, NUM_CORES - 1));
    in_opn   = 2'($urandom_range(0, 2));
    in_addr  = {2'($urandom), $urandom};
    in_addr[6] = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b0;
    drive_legal(64'd0);
    tick();
    tick();
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    vectors++; if (cur_cyc !== 64'd0) begin miscompares++; $display("FAIL reset_cur_cyc: got %0d want 0", cur_cyc); end
    vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", full); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (drop_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
    vectors++; if (out_req !== req_t'('0)) begin miscompares++; $display("FAIL reset_out_req: got %h want 0", out_req); end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_timestamp_hold();
    reset_dut();
    in_valid = 1'b1; in_cyc = 64'd10; in_core = 4'd0; in_opn = 2'd0; in_addr = 34'h0_0001_2384;
    for (int c = 0; c < 10; c++) begin
      #1;
      vectors++; if (cur_cyc !== 64'(c)) begin miscompares++; $display("FAIL hold_cur_cyc: got %0d want %0d", cur_cyc, c); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL hold_in_ready: got %b want 0 at cyc %0d", in_ready, c); end
      tick();
    end
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL hold_due_ready: got %b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL hold_no_bypass: got %b want 0", out_valid); end
    tick();
    in_valid = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL hold_out_valid: got %b want 1", out_valid); end
    vectors++; if (cur_cyc !== 64'd11) begin miscompares++; $display("FAIL hold_out_cyc: got %0d want 11", cur_cyc); end
    vectors++; if (out_req.bank_group !== 3'd7) begin miscompares++; $display("FAIL hold_bg: got %0d want 7", out_req.bank_group); end
    vectors++; if (out_req.bank !== 2'd0) begin miscompares++; $display("FAIL hold_bank: got %0d want 0", out_req.bank); end
    vectors++; if (out_req.row !== 16'h0000) begin miscompares++; $display("FAIL hold_row: got %h want 0000", out_req.row); end
    vectors++; if (out_req.column !== 10'h121) begin miscompares++; $display("FAIL hold_column: got %h want 121", out_req.column); end
    if (m_q.size() != 0) begin
      vectors++; if (out_req !== m_q[0]) begin miscompares++; $display("FAIL hold_entry: got %h want %h", out_req, m_q[0]); end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_illegal_drop();
    reset_dut();
    for (int i = 0; i < DEPTH; i++) begin
      drive_legal(m_cyc);
      tick();
    end
    in_valid = 1'b0;
    #1;
    vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL drop_pre_full: got %b want 1", full); end
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_cyc = m_cyc; in_core = 4'd0; in_opn = 2'd0; in_addr = 34'h100;
      if (k == 0) in_core = 4'd13;
      if (k == 1) in_opn = 2'd3;
      if (k == 2) in_addr = 34'h40;
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL drop_ready_%0d: got %b want 1", k, in_ready); end
      tick();
    end
    in_valid = 1'b0;
    #1;
    vectors++; if (drop_cnt !== 16'd3) begin miscompares++; $display("FAIL drop_cnt: got %0d want 3", drop_cnt); end
    vectors++; if (count !== 5'd16) begin miscompares++; $display("FAIL drop_count: got %0d want 16", count); end
  endtask

  task automatic test_fill_backpressure();
    reset_dut();
    for (int i = 0; i < DEPTH; i++) begin
      drive_legal(m_cyc);
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready_%0d: got %b want 1", i, in_ready); end
      tick();
    end
    drive_legal(m_cyc);
    #1;
    vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL fill_full: got %b want 1", full); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL fill_stall: got %b want 0", in_ready); end
    tick();
    out_ready = 1'b1;
    #1;
    vectors++; if (count !== 5'd16) begin miscompares++; $display("FAIL fill_hold_count: got %0d want 16", count); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL fill_pop_ready: got %b want 0", in_ready); end
    vectors++; if (out_req !== m_q[0]) begin miscompares++; $display("FAIL fill_head: got %h want %h", out_req, m_q[0]); end
    tick();
    out_ready = 1'b0;
    #1;
    vectors++; if (count !== 5'd15) begin miscompares++; $display("FAIL fill_after_pop: got %0d want 15", count); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL fill_resume: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    vectors++; if (count !== 5'd16) begin miscompares++; $display("FAIL fill_refill: got %0d want 16", count); end
    vectors++; if (out_req !== m_q[0]) begin miscompares++; $display("FAIL fill_head2: got %h want %h", out_req, m_q[0]); end
  endtask

  task automatic test_push_pop();
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      drive_legal(m_cyc);
      tick();
    end
    drive_legal(m_cyc);
    out_ready = 1'b1;
    #1;
    vectors++; if (count !== 5'd5) begin miscompares++; $display("FAIL pp_pre_count: got %0d want 5", count); end
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    vectors++; if (count !== 5'd5) begin miscompares++; $display("FAIL pp_count: got %0d want 5", count); end
    vectors++; if (out_req !== m_q[0]) begin miscompares++; $display("FAIL pp_head: got %h want %h", out_req, m_q[0]); end
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 1) == 1) drive_legal(m_cyc);
      else in_valid = 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      vectors++; if (count !== 5'(m_q.size())) begin miscompares++; $display("FAIL pp_mix_count: got %0d want %0d", count, m_q.size()); end
      if (m_q.size() != 0) begin
        vectors++; if (out_req !== m_q[0]) begin miscompares++; $display("FAIL pp_mix_head: got %h want %h", out_req, m_q[0]); end
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    reset_dut();
    for (int i = 0; i < 9; i++) begin
      drive_legal(m_cyc);
      tick();
    end
    in_valid = 1'b1; in_cyc = m_cyc; in_core = 4'd14; in_opn = 2'd0; in_addr = 34'h0;
    tick();
    drive_legal(m_cyc);
    rst = 1'b1;
    #1;
    vectors++; if (count !== 5'd9) begin miscompares++; $display("FAIL mid_pre_count: got %0d want 9", count); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL mid_count: got %0d want 0", count); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
    vectors++; if (cur_cyc !== 64'd0) begin miscompares++; $display("FAIL mid_cur_cyc: got %0d want 0", cur_cyc); end
    vectors++; if (drop_cnt !== 16'd0) begin miscompares++; $display("FAIL mid_drop_cnt: got %0d want 0", drop_cnt); end
  endtask

`ifdef DDR5_REQQ_STATS_EN
  task automatic test_stats();
    reset_dut();
    for (int i = 0; i < DEPTH; i++) begin
      drive_legal(m_cyc);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    #1;
    vectors++; if (full_cycles !== 32'd7) begin miscompares++; $display("FAIL stats_full_cycles: got %0d want 7", full_cycles); end
    vectors++; if (max_count !== 5'd16) begin miscompares++; $display("FAIL stats_max_count: got %0d want 16", max_count); end
  endtask
`endif

  task automatic test_random();
    bit pending;
    pending = 1'b0;
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      if (!pending && $urandom_range(0, 3) != 0) begin
        pending = 1'b1;
        drive_legal(m_cyc + 64'($urandom_range(0, 4)));
        case ($urandom_range(0, 7))
          0:       in_core = 4'($urandom_range(NUM_CORES, 15));
          1:       in_opn  = 2'd3;
          2:       in_addr[6] = 1'b1;
          default: ;
        endcase
      end
      in_valid  = pending;
      out_ready = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      #1;
      vectors++; if (in_ready !== m_ready()) begin miscompares++; $display("FAIL rnd_in_ready: got %b want %b", in_ready, m_ready()); end
      vectors++; if (count !== 5'(m_q.size())) begin miscompares++; $display("FAIL rnd_count: got %0d want %0d", count, m_q.size()); end
      vectors++; if (out_valid !== (m_q.size() != 0)) begin miscompares++; $display("FAIL rnd_out_valid: got %b want %b", out_valid, m_q.size() != 0); end
      vectors++; if (full !== (m_q.size() == DEPTH)) begin miscompares++; $display("FAIL rnd_full: got %b", full); end
      vectors++; if (drop_cnt !== 16'(m_drop)) begin miscompares++; $display("FAIL rnd_drop_cnt: got %0d want %0d", drop_cnt, m_drop); end
      vectors++; if (cur_cyc !== m_cyc) begin miscompares++; $display("FAIL rnd_cur_cyc: got %0d want %0d", cur_cyc, m_cyc); end
      if (m_q.size() != 0) begin
        vectors++; if (out_req !== m_q[0]) begin miscompares++; $display("FAIL rnd_head: got %h want %h", out_req, m_q[0]); end
      end
      if (pending && m_ready()) pending = 1'b0;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_cyc = '0; in_core = '0; in_opn = '0; in_addr = '0;
    m_cyc = '0; m_drop = 0;
    test_reset();
    test_timestamp_hold();
    test_illegal_drop();
    test_fill_backpressure();
    test_push_pop();
    test_reset_mid();
`ifdef DDR5_REQQ_STATS_EN
    test_stats();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
